// File: rtl/spi_mnrch_gen.sv
// spi_mnrch_gen: parametrised SPI monarch with runtime CPOL/CPHA and NUM_SS active-low selects.
// Optional macro SPI_MNRCH_GEN_LSB_FIRST_EN adds the lsb_first input for LSB-first framing.
module spi_mnrch_gen #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 5,
    parameter int NUM_SS = 1,
    localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snd,
    input  logic [DATA_W-1:0] cmd,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_MNRCH_GEN_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] resp,
    output logic [NUM_SS-1:0] SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int HW   = DIV_W - 1;
    localparam int HC_W = $clog2(2 * DATA_W + 1);
    localparam logic [HC_W-1:0] LAST_HALF = HC_W'(2 * DATA_W);
    localparam logic [HC_W-1:0] LAST_EDGE = HC_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

    state_t            state;
    logic [HW-1:0]     cnt;
    logic [HC_W-1:0]   hcnt;
    logic [HC_W-1:0]   edge_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_in;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsb_q;
    logic              lsb_in;
    logic              half_end;
    logic              toggle_now;
    logic              sample_now;
    logic              mosi_now;
    logic              next_bit;
    logic              first_bit;

`ifdef SPI_MNRCH_GEN_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
    assign lsb_q  = 1'b0;
`endif

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        ss_decode = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (sel == SEL_W'(i)) ss_decode[i] = 1'b0;
    endfunction

    // Edge 0 is launched as FRONT ends; edge h is launched as SHIFT half-period h ends.
    // Even edges are leading; the last SHIFT half-period has no toggle so SCLK rests at idle.
    assign half_end   = (cnt == {HW{1'b1}});
    assign edge_idx   = (state == FRONT) ? '0 : hcnt;
    assign toggle_now = half_end && ((state == FRONT) || ((state == SHIFT) && (hcnt != LAST_HALF)));
    assign sample_now = toggle_now && (edge_idx[0] == cpha_q);
    assign mosi_now   = toggle_now && (edge_idx[0] != cpha_q) && (cpha_q || (edge_idx != LAST_EDGE));
    assign next_bit   = lsb_q ? shreg[0] : shreg[DATA_W-1];
    assign shreg_in   = lsb_q ? {MISO, shreg[DATA_W-1:1]} : {shreg[DATA_W-2:0], MISO};
    assign first_bit  = lsb_in ? cmd[0] : cmd[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hcnt   <= '0;
            shreg  <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
`ifdef SPI_MNRCH_GEN_LSB_FIRST_EN
            lsb_q  <= 1'b0;
`endif
            busy   <= 1'b0;
            done   <= 1'b0;
            resp   <= '0;
            SS_n   <= '1;
            SCLK   <= 1'b0;
            MOSI   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    SCLK <= cpol_q;
                    if (snd) begin
                        state  <= FRONT;
                        cnt    <= '0;
                        hcnt   <= '0;
                        shreg  <= cmd;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
`ifdef SPI_MNRCH_GEN_LSB_FIRST_EN
                        lsb_q  <= lsb_in;
`endif
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        SS_n   <= ss_decode(ss_sel);
                        SCLK   <= cpol;
                        if (!cpha) MOSI <= first_bit;
                    end
                end
                FRONT: begin
                    cnt <= cnt + 1'b1;
                    if (half_end) begin
                        state <= SHIFT;
                        hcnt  <= HC_W'(1);
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (half_end) begin
                        if (hcnt == LAST_HALF) state <= BACK;
                        else                   hcnt  <= hcnt + 1'b1;
                    end
                end
                BACK: begin
                    cnt <= cnt + 1'b1;
                    if (half_end) begin
                        state <= IDLE;
                        SS_n  <= '1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        resp  <= shreg;
                    end
                end
                default: state <= IDLE;
            endcase
            if (toggle_now) SCLK  <= ~SCLK;
            if (sample_now) shreg <= shreg_in;
            if (mosi_now)   MOSI  <= next_bit;
        end
    end

endmodule

// File: tb/tb_spi_mnrch_gen.sv
// Directed testbench for spi_mnrch_gen: 16-bit/3-select instance with a mode-aware slave model,
// plus an 8-bit/DIV_W=3 instance exercising the optional SPI_MNRCH_GEN_LSB_FIRST_EN build.
module tb_spi_mnrch_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        snd = 1'b0;
    logic [15:0] cmd = '0;
    logic [1:0]  ss_sel = '0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        busy, done;
    logic [15:0] resp;
    logic [2:0]  ss_n;
    logic        sclk, mosi;
    logic        miso = 1'b0;

    logic        snd8 = 1'b0;
    logic [7:0]  cmd8 = '0;
    logic [0:0]  ss_sel8 = '0;
    logic        busy8, done8;
    logic [7:0]  resp8;
    logic [0:0]  ss_n8;
    logic        sclk8, mosi8;
    logic        miso8 = 1'b0;
`ifdef SPI_MNRCH_GEN_LSB_FIRST_EN
    logic        lsb_first = 1'b0;
    logic        lsb8 = 1'b0;
`endif

    spi_mnrch_gen #(.DATA_W(16), .DIV_W(5), .NUM_SS(3)) dut (
        .clk(clk), .rst_n(rst_n), .snd(snd), .cmd(cmd), .ss_sel(ss_sel),
        .cpol(cpol), .cpha(cpha),
`ifdef SPI_MNRCH_GEN_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .busy(busy), .done(done), .resp(resp), .SS_n(ss_n),
        .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    spi_mnrch_gen #(.DATA_W(8), .DIV_W(3), .NUM_SS(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .snd(snd8), .cmd(cmd8), .ss_sel(ss_sel8),
        .cpol(1'b0), .cpha(1'b0),
`ifdef SPI_MNRCH_GEN_LSB_FIRST_EN
        .lsb_first(lsb8),
`endif
        .busy(busy8), .done(done8), .resp(resp8), .SS_n(ss_n8),
        .SCLK(sclk8), .MOSI(mosi8), .MISO(miso8)
    );

    int   checks = 0;
    int   failures = 0;
    int   ss_low_cnt = 0;
    int   busy_cnt = 0;
    int   rise_cnt = 0;
    int   ss8_low_cnt = 0;
    logic ss_seen_low = 1'b0;

    always @(negedge clk) begin
        if (ss_n != 3'b111) begin
            ss_low_cnt++;
            ss_seen_low = 1'b1;
        end
        if (busy) busy_cnt++;
        if (ss_n8 == 1'b0) ss8_low_cnt++;
    end

    always @(posedge sclk) rise_cnt++;

    // Slave model: answers 0x3C5A MSB first and captures MOSI according to the frame's mode.
    logic [15:0] slv_tx = 16'h3C5A;
    logic [15:0] slv_rx = '0;
    logic        slv_cpol = 1'b0;
    logic        slv_cpha = 1'b0;
    int          slv_edge = 0;
    wire         ss_act = (ss_n != 3'b111);

    always @(posedge ss_act) begin
        slv_edge = 0;
        slv_rx   = '0;
        if (!slv_cpha) miso = slv_tx[15];
    end

    always @(sclk) begin
        if (ss_act) begin
            if (sclk != slv_cpol) begin
                if (slv_cpha) miso = slv_tx[15 - slv_edge / 2];
                else          slv_rx = {slv_rx[14:0], mosi};
                slv_edge++;
            end else if (slv_edge % 2 == 1) begin
                if (slv_cpha)                slv_rx = {slv_rx[14:0], mosi};
                else if (slv_edge / 2 < 15)  miso = slv_tx[14 - slv_edge / 2];
                slv_edge++;
            end
        end
    end

    // 8-bit slave: 1 at select, then alternates on every falling SCLK.
    always @(negedge ss_n8[0]) miso8 = 1'b1;
    always @(negedge sclk8) if (ss_n8[0] == 1'b0) miso8 = ~miso8;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; snd is high for exactly one rising edge.
    task automatic applyStimulus(input logic [15:0] c, input logic [1:0] sel,
                                 input logic pol, input logic pha);
        cmd = c; ss_sel = sel; cpol = pol; cpha = pha;
        slv_cpol = pol; slv_cpha = pha;
        ss_low_cnt = 0; busy_cnt = 0; rise_cnt = 0; ss_seen_low = 1'b0;
        snd = 1'b1;
        @(negedge clk);
        snd = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput(tag, 32'(done), 32'd1);
    endtask

    initial begin
        logic [7:0] exp_resp8;
        logic       exp_first8;
        int         n8;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ss_n", 32'(ss_n), 32'h7);
        checkOutput("rst_sclk", 32'(sclk), 32'h0);
        checkOutput("rst_mosi", 32'(mosi), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_resp", 32'(resp), 32'h0);

        $display("[TB] mode 0 frame");
        applyStimulus(16'hA5C3, 2'd0, 1'b0, 1'b0);
        checkOutput("m0_ss_n", 32'(ss_n), 32'h6);
        checkOutput("m0_busy", 32'(busy), 32'h1);
        waitDone("m0_timeout", 700);
        checkOutput("m0_resp", 32'(resp), 32'h3C5A);
        checkOutput("m0_mosi_stream", 32'(slv_rx), 32'hA5C3);
        checkOutput("m0_ss_low", 32'(ss_low_cnt), 32'd544);
        checkOutput("m0_rises", 32'(rise_cnt), 32'd16);
        checkOutput("m0_busy_end", 32'(busy), 32'h0);

        $display("[TB] mode 3 frame");
        applyStimulus(16'hA5C3, 2'd0, 1'b1, 1'b1);
        checkOutput("m3_sclk_idle_front", 32'(sclk), 32'h1);
        waitDone("m3_timeout", 700);
        checkOutput("m3_resp", 32'(resp), 32'h3C5A);
        checkOutput("m3_mosi_stream", 32'(slv_rx), 32'hA5C3);
        checkOutput("m3_ss_low", 32'(ss_low_cnt), 32'd544);
        checkOutput("m3_sclk_idle_back", 32'(sclk), 32'h1);

        $display("[TB] ignored snd mid-frame, then back-to-back");
        applyStimulus(16'hA5C3, 2'd1, 1'b0, 1'b0);
        checkOutput("ign_ss_n", 32'(ss_n), 32'h5);
        repeat (100) @(negedge clk);
        cmd = 16'hFFFF; cpol = 1'b1; ss_sel = 2'd2;
        snd = 1'b1;
        @(negedge clk);
        snd = 1'b0;
        waitDone("ign_timeout", 700);
        checkOutput("ign_resp", 32'(resp), 32'h3C5A);
        checkOutput("ign_mosi_stream", 32'(slv_rx), 32'hA5C3);
        checkOutput("ign_ss_low", 32'(ss_low_cnt), 32'd544);
        checkOutput("ign_sclk_idle", 32'(sclk), 32'h0);
        checkOutput("b2b_gap_ss_n", 32'(ss_n), 32'h7);
        applyStimulus(16'h1234, 2'd0, 1'b0, 1'b0);
        checkOutput("b2b_done_clr", 32'(done), 32'h0);
        checkOutput("b2b_busy", 32'(busy), 32'h1);
        waitDone("b2b_timeout", 700);
        checkOutput("b2b_resp", 32'(resp), 32'h3C5A);
        checkOutput("b2b_mosi_stream", 32'(slv_rx), 32'h1234);

        $display("[TB] slave select decode");
        applyStimulus(16'h0F0F, 2'd2, 1'b0, 1'b0);
        checkOutput("sel2_ss_n", 32'(ss_n), 32'h3);
        waitDone("sel2_timeout", 700);
        checkOutput("sel2_resp", 32'(resp), 32'h3C5A);
        miso = 1'b0;
        applyStimulus(16'h0F0F, 2'd3, 1'b0, 1'b0);
        checkOutput("sel3_ss_n", 32'(ss_n), 32'h7);
        waitDone("sel3_timeout", 700);
        checkOutput("sel3_never_low", 32'(ss_seen_low), 32'h0);
        checkOutput("sel3_busy_len", 32'(busy_cnt), 32'd544);
        checkOutput("sel3_done", 32'(done), 32'h1);
        checkOutput("sel3_resp", 32'(resp), 32'h0);

        $display("[TB] reset mid-frame");
        applyStimulus(16'hA5C3, 2'd0, 1'b0, 1'b0);
        repeat (220) @(negedge clk);
        checkOutput("pre_rst_sclk", 32'(sclk), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_ss_n", 32'(ss_n), 32'h7);
        checkOutput("arst_sclk", 32'(sclk), 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        checkOutput("arst_done", 32'(done), 32'h0);
        checkOutput("arst_mosi", 32'(mosi), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'hA5C3, 2'd0, 1'b0, 1'b0);
        waitDone("post_rst_timeout", 700);
        checkOutput("post_rst_resp", 32'(resp), 32'h3C5A);
        checkOutput("post_rst_mosi_stream", 32'(slv_rx), 32'hA5C3);
        checkOutput("post_rst_ss_low", 32'(ss_low_cnt), 32'd544);

        $display("[TB] 8-bit instance");
`ifdef SPI_MNRCH_GEN_LSB_FIRST_EN
        lsb8 = 1'b1;
        exp_first8 = 1'b1;
        exp_resp8  = 8'h55;
`else
        exp_first8 = 1'b0;
        exp_resp8  = 8'hAA;
`endif
        cmd8 = 8'h01;
        ss8_low_cnt = 0;
        snd8 = 1'b1;
        @(negedge clk);
        snd8 = 1'b0;
        checkOutput("w8_first_mosi", 32'(mosi8), 32'(exp_first8));
        n8 = 0;
        while (!done8 && n8 < 200) begin
            @(negedge clk);
            n8++;
        end
        checkOutput("w8_done", 32'(done8), 32'h1);
        checkOutput("w8_resp", 32'(resp8), 32'(exp_resp8));
        checkOutput("w8_ss_low", 32'(ss8_low_cnt), 32'd72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
